// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit.
//   IDLE/BUSY/DONE : FSM state encoding used by square_root_iter
//   rem_w()        : partial-remainder width for a given root width
package sqrt_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE = 2'd0;
  localparam logic [STATE_W-1:0] BUSY = 2'd1;
  localparam logic [STATE_W-1:0] DONE = 2'd2;

  // Remainder never exceeds 2*root, so one bit more than the root suffices.
  function automatic int unsigned rem_w(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/square_step.sv
// One combinational restoring square-root iteration (MSB first).
//   rem_in   : partial remainder so far (WIDTH+1 bits)
//   root_in  : partial root so far (WIDTH bits)
//   bits     : next two radicand bits
//   rem_out  : updated partial remainder
//   root_out : partial root with one more bit resolved
module square_step
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [rem_w(WIDTH)-1:0] rem_in,
  input  logic [WIDTH-1:0]        root_in,
  input  logic [1:0]              bits,
  output logic [rem_w(WIDTH)-1:0] rem_out,
  output logic [WIDTH-1:0]        root_out
);

  localparam int unsigned RW = rem_w(WIDTH);
  localparam int unsigned DW = WIDTH + 4;

  logic [DW-1:0] minuend;
  logic [DW-1:0] subtrahend;
  logic [DW-1:0] trial;
  logic          fits;
  logic          unused_bits;

  // One guard bit above the WIDTH+3 trial difference makes the borrow explicit.
  assign minuend    = {1'b0, rem_in, bits};
  assign subtrahend = {2'b00, root_in, 2'b01};
  assign trial      = minuend - subtrahend;
  assign fits       = ~trial[DW-1];

  // Either candidate is bounded by 2*new_root, so the low RW bits hold it exactly.
  assign rem_out  = fits ? trial[RW-1:0] : minuend[RW-1:0];
  // The root MSB is still zero whenever another bit is shifted in.
  assign root_out = {root_in[WIDTH-2:0], fits};

  assign unused_bits = ^{trial[DW-2:RW], minuend[DW-1:RW], root_in[WIDTH-1]};

endmodule

// File: rtl/square_root_iter.sv
// Iterative integer square root with valid/ready handshakes, STEPS root bits per cycle.
//   clk, rst           : clock and asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (radicand, in_tag)
//   radicand           : 2*WIDTH-bit unsigned operand
//   in_tag             : opaque tag carried with the operation
//   out_valid/out_ready: result handshake (dout, remainder, out_tag)
//   dout               : floor(sqrt(radicand))
//   remainder          : radicand - dout^2
//   out_tag            : tag of the returned result
module square_root_iter
  import sqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = 1,
  parameter int unsigned TAG_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*WIDTH-1:0]      radicand,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic [rem_w(WIDTH)-1:0] remainder,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int unsigned RW     = rem_w(WIDTH);
  localparam int unsigned OPW    = 2 * WIDTH;
  localparam int unsigned N_ITER = WIDTH / STEPS;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int unsigned SHIFT  = 2 * STEPS;

  // Reject parameter sets the step chain cannot cover exactly.
  if (WIDTH < 2 || STEPS < 1 || (WIDTH % STEPS) != 0) begin : g_bad_params
    $error("square_root_iter: WIDTH must be >= 2 and divisible by STEPS");
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_d;
  logic [CNT_W-1:0]   cnt;
  logic [OPW-1:0]     opnd;
  logic               accept;

  logic [RW-1:0]    rem_chain  [STEPS+1];
  logic [WIDTH-1:0] root_chain [STEPS+1];

  // dout/remainder double as the working root/remainder while BUSY.
  assign rem_chain[0]  = remainder;
  assign root_chain[0] = dout;

  // STEPS chained iterations consume the top 2*STEPS operand bits each cycle.
  for (genvar j = 0; j < STEPS; j++) begin : g_step
    square_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_in  (rem_chain[j]),
      .root_in (root_chain[j]),
      .bits    (opnd[OPW-1-2*j -: 2]),
      .rem_out (rem_chain[j+1]),
      .root_out(root_chain[j+1])
    );
  end

  // A waiting result can be replaced in the same cycle it is consumed.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (cnt == '0) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand, iteration and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opnd      <= '0;
      dout      <= '0;
      remainder <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      out_valid <= (state_d == DONE);
      if (accept) begin
        opnd      <= radicand;
        out_tag   <= in_tag;
        dout      <= '0;
        remainder <= '0;
        cnt       <= CNT_W'(N_ITER - 1);
      end else if (state == BUSY) begin
        opnd      <= opnd << SHIFT;
        dout      <= root_chain[STEPS];
        remainder <= rem_chain[STEPS];
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_square_root_iter.sv
// Self-checking bench for square_root_iter across several WIDTH/STEPS configurations.
module tb_square_root_iter;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [31:0] rad       [NI];
  logic [3:0]  in_tag    [NI];
  logic [3:0]  out_tag   [NI];
  logic [15:0] dout      [NI];
  logic [16:0] rem       [NI];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Instances: 0=4/1, 1=4/2, 2=4/4, 3=8/2, 4=16/4 (WIDTH/STEPS)
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WG = (g == 3) ? 8 : (g == 4) ? 16 : 4;
    localparam int unsigned SG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 2 : 4;
    logic [2*WG-1:0] rad_l;
    logic [WG-1:0]   dout_l;
    logic [WG:0]     rem_l;
    logic [3:0]      tag_l;
    logic            rdy_l;
    logic            ov_l;

    assign rad_l = rad[g][2*WG-1:0];

    square_root_iter #(
      .WIDTH(WG),
      .STEPS(SG),
      .TAG_W(4)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (rdy_l),
      .radicand (rad_l),
      .in_tag   (in_tag[g]),
      .out_valid(ov_l),
      .out_ready(out_ready[g]),
      .dout     (dout_l),
      .remainder(rem_l),
      .out_tag  (tag_l)
    );

    assign in_ready[g]  = rdy_l;
    assign out_valid[g] = ov_l;
    assign out_tag[g]   = tag_l;
    assign dout[g]      = 16'(dout_l);
    assign rem[g]       = 17'(rem_l);
  end

  function automatic int unsigned width_of(input int i);
    return (i == 3) ? 8 : (i == 4) ? 16 : 4;
  endfunction

  // Reference: largest r with r*r <= x, by bisection.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo = 0;
    longint unsigned hi = 64'd65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one operand (caller ensures in_ready), then scramble the inputs.
  task automatic start_op(input int i, input logic [31:0] r, input logic [3:0] t);
    rad[i]      = r;
    in_tag[i]   = t;
    in_valid[i] = 1'b1;
    tick();
    in_valid[i] = 1'b0;
    rad[i]      = ~r;
    in_tag[i]   = ~t;
  endtask

  // Cycle index (handshake cycle = 0) in which out_valid is first seen.
  task automatic wait_valid(input int i, output int cyc);
    cyc = 1;
    while (out_valid[i] !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic consume(input int i);
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      compared++;
      if ({out_valid[i], dout[i], rem[i], out_tag[i]} !== '0) begin
        mismatched++;
        $display("FAIL reset[%0d] during reset: valid=%b dout=%0h rem=%0h tag=%0h, want all 0",
                 i, out_valid[i], dout[i], rem[i], out_tag[i]);
      end
    end
    @(negedge clk) rst = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      compared++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset[%0d] after release: in_ready=%b out_valid=%b, want 1 0",
                 i, in_ready[i], out_valid[i]);
      end
    end
  endtask

  task automatic test_directed();
    int          inst  [4] = '{0, 0, 1, 4};
    logic [31:0] r     [4] = '{32'd200, 32'd0, 32'd255, 32'hFFFF_FFFF};
    logic [3:0]  t     [4] = '{4'd5, 4'd2, 4'd9, 4'd1};
    logic [15:0] exp_d [4] = '{16'd14, 16'd0, 16'd15, 16'hFFFF};
    logic [16:0] exp_r [4] = '{17'd4, 17'd0, 17'd30, 17'h1FFFE};
    int          lat   [4] = '{5, 5, 3, 5};
    int          cyc;
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (in_ready[inst[k]] !== 1'b1) begin
        mismatched++;
        $display("FAIL directed[%0d] in_ready idle: got %b, want 1", k, in_ready[inst[k]]);
      end
      start_op(inst[k], r[k], t[k]);
      wait_valid(inst[k], cyc);
      compared++;
      if (cyc != lat[k]) begin
        mismatched++;
        $display("FAIL directed[%0d] latency: got %0d, want %0d", k, cyc, lat[k]);
      end
      compared++;
      if (dout[inst[k]] !== exp_d[k] || rem[inst[k]] !== exp_r[k] || out_tag[inst[k]] !== t[k]) begin
        mismatched++;
        $display("FAIL directed[%0d] result: dout=%0h rem=%0h tag=%0h, want %0h %0h %0h",
                 k, dout[inst[k]], rem[inst[k]], out_tag[inst[k]], exp_d[k], exp_r[k], t[k]);
      end
      consume(inst[k]);
      compared++;
      if (out_valid[inst[k]] !== 1'b0) begin
        mismatched++;
        $display("FAIL directed[%0d] out_valid after consume: got %b, want 0", k, out_valid[inst[k]]);
      end
    end
  endtask

  task automatic test_backpressure();
    int i = 3;
    int cyc;
    start_op(i, 32'd1000, 4'h6);
    wait_valid(i, cyc);
    in_valid[i] = 1'b1;
    rad[i]      = 32'd5000;
    in_tag[i]   = 4'h7;
    for (int c = 0; c < 10; c++) begin
      compared++;
      if ({out_valid[i], in_ready[i], dout[i], rem[i], out_tag[i]} !==
          {1'b1, 1'b0, 16'd31, 17'd39, 4'h6}) begin
        mismatched++;
        $display("FAIL backpressure hold %0d: valid=%b in_ready=%b dout=%0d rem=%0d tag=%0h, want 1 0 31 39 6",
                 c, out_valid[i], in_ready[i], dout[i], rem[i], out_tag[i]);
      end
      tick();
    end
    out_ready[i] = 1'b1;
    #1;
    compared++;
    if (in_ready[i] !== 1'b1) begin
      mismatched++;
      $display("FAIL backpressure in_ready with out_ready: got %b, want 1", in_ready[i]);
    end
    tick();
    out_ready[i] = 1'b0;
    in_valid[i]  = 1'b0;
    rad[i]       = 32'd7;
    compared++;
    if (out_valid[i] !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure out_valid after swap: got %b, want 0", out_valid[i]);
    end
    wait_valid(i, cyc);
    compared++;
    if (cyc != 5 || dout[i] !== 16'd70 || rem[i] !== 17'd100 || out_tag[i] !== 4'h7) begin
      mismatched++;
      $display("FAIL backpressure second op: cyc=%0d dout=%0d rem=%0d tag=%0h, want 5 70 100 7",
               cyc, dout[i], rem[i], out_tag[i]);
    end
    consume(i);
  endtask

  task automatic test_busy_ignore();
    int i = 4;
    int cyc;
    start_op(i, 32'd12345678, 4'h3);
    for (int c = 0; c < 3; c++) begin
      in_valid[i] = 1'b1;
      rad[i]      = 32'd99;
      in_tag[i]   = 4'hE;
      #1;
      compared++;
      if (in_ready[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL busy_ignore in_ready %0d: got %b, want 0", c, in_ready[i]);
      end
      tick();
    end
    in_valid[i] = 1'b0;
    wait_valid(i, cyc);
    compared++;
    if (dout[i] !== 16'd3513 || rem[i] !== 17'd4509 || out_tag[i] !== 4'h3) begin
      mismatched++;
      $display("FAIL busy_ignore result: dout=%0d rem=%0d tag=%0h, want 3513 4509 3",
               dout[i], rem[i], out_tag[i]);
    end
    consume(i);
  endtask

  task automatic test_reset_abort();
    int  i = 0;
    int  cyc;
    bit  stray = 0;
    // Abort while BUSY.
    start_op(i, 32'd200, 4'h4);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    compared++;
    if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || dout[i] !== 16'd0 || rem[i] !== 17'd0) begin
      mismatched++;
      $display("FAIL reset_busy async: valid=%b in_ready=%b dout=%0d rem=%0d, want 0 1 0 0",
               out_valid[i], in_ready[i], dout[i], rem[i]);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      if (out_valid[i] !== 1'b0) stray = 1;
      tick();
    end
    compared++;
    if (stray || in_ready[i] !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_busy aftermath: stray_result=%b in_ready=%b, want 0 1", stray, in_ready[i]);
    end
    start_op(i, 32'd9, 4'h8);
    wait_valid(i, cyc);
    compared++;
    if (cyc != 5 || dout[i] !== 16'd3 || rem[i] !== 17'd0 || out_tag[i] !== 4'h8) begin
      mismatched++;
      $display("FAIL reset_busy next op: cyc=%0d dout=%0d rem=%0d tag=%0h, want 5 3 0 8",
               cyc, dout[i], rem[i], out_tag[i]);
    end
    // Abort while DONE with the result still pending.
    #2 rst = 1'b1;
    #1;
    compared++;
    if (out_valid[i] !== 1'b0 || dout[i] !== 16'd0 || out_tag[i] !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_done async: valid=%b dout=%0d tag=%0h, want 0 0 0",
               out_valid[i], dout[i], out_tag[i]);
    end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  // Random traffic with random gaps and backpressure, scoreboarded against isqrt().
  task automatic test_random(input int i, input int n_ops);
    longint unsigned qr[$];
    logic [3:0]      qt[$];
    longint unsigned mask = (64'd1 << (2 * width_of(i))) - 1;
    longint unsigned r = 0, e, want_r, d, m;
    logic [3:0]      tg = 4'h0;
    logic [3:0]      want_t;
    int              sent = 0, got = 0, cyc = 0, sel;
    bit              pend = 0, fire_in, fire_out;
    while (got < n_ops && cyc < 60000) begin
      if (!pend && sent < n_ops && $urandom_range(3) != 0) begin
        sel = $urandom_range(15);
        r = (sel == 0) ? 64'd0 : (sel == 1) ? mask : (longint'($urandom) & mask);
        rad[i]      = 32'(r);
        in_tag[i]   = tg;
        in_valid[i] = 1'b1;
        pend        = 1;
      end
      out_ready[i] = ($urandom_range(3) != 0);
      #1;
      fire_in  = in_valid[i] && in_ready[i];
      fire_out = out_valid[i] && out_ready[i];
      if (fire_out) begin
        compared++;
        if (qr.size() == 0) begin
          mismatched++;
          $display("FAIL rand[%0d] unexpected result dout=%0h, want none pending", i, dout[i]);
        end else begin
          want_r = qr.pop_front();
          want_t = qt.pop_front();
          e = isqrt(want_r);
          d = longint'(dout[i]);
          m = longint'(rem[i]);
          if (dout[i] !== 16'(e)) begin
            mismatched++;
            $display("FAIL rand[%0d] dout for %0h: got %0h, want %0h", i, want_r, dout[i], e);
          end
          compared++;
          if (rem[i] !== 17'(want_r - e * e)) begin
            mismatched++;
            $display("FAIL rand[%0d] remainder for %0h: got %0h, want %0h", i, want_r, rem[i], want_r - e * e);
          end
          compared++;
          if (out_tag[i] !== want_t) begin
            mismatched++;
            $display("FAIL rand[%0d] tag order: got %0h, want %0h", i, out_tag[i], want_t);
          end
          compared++;
          if (d * d + m != want_r) begin
            mismatched++;
            $display("FAIL rand[%0d] dout^2+rem: got %0h, want %0h", i, d * d + m, want_r);
          end
          compared++;
          if (m > 2 * d) begin
            mismatched++;
            $display("FAIL rand[%0d] rem bound: got rem %0h, want <= %0h", i, m, 2 * d);
          end
        end
        got++;
      end
      if (fire_in) begin
        qr.push_back(r);
        qt.push_back(tg);
        tg = tg + 4'h1;
        sent++;
        pend = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!pend) in_valid[i] = 1'b0;
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b0;
    compared++;
    if (got != n_ops) begin
      mismatched++;
      $display("FAIL rand[%0d] completion: got %0d results, want %0d", i, got, n_ops);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      rad[k]       = '0;
      in_tag[k]    = '0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_ignore();
    test_reset_abort();
    fork
      test_random(0, 2500);
      test_random(2, 2500);
      test_random(3, 2500);
      test_random(4, 2500);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
